// File: rtl/multicycle_sequencer_pkg.sv
// multicycle_sequencer_pkg: shared MIPS opcode/funct codes, FSM state codes, instruction classes and PC source selects
// Package mips_defs is imported by instr_classifier and multicycle_sequencer; it has no ports.
package mips_defs;
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] FN_SLL    = 6'h00;
    localparam logic [5:0] FN_SRL    = 6'h02;
    localparam logic [5:0] FN_SRA    = 6'h03;
    localparam logic [5:0] FN_SLLV   = 6'h04;
    localparam logic [5:0] FN_SRLV   = 6'h06;
    localparam logic [5:0] FN_SRAV   = 6'h07;
    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_ADD    = 6'h20;
    localparam logic [5:0] FN_ADDU   = 6'h21;
    localparam logic [5:0] FN_SUB    = 6'h22;
    localparam logic [5:0] FN_SUBU   = 6'h23;
    localparam logic [5:0] FN_AND    = 6'h24;
    localparam logic [5:0] FN_OR     = 6'h25;
    localparam logic [5:0] FN_XOR    = 6'h26;
    localparam logic [5:0] FN_NOR    = 6'h27;
    localparam logic [5:0] FN_SLT    = 6'h2A;
    localparam logic [5:0] FN_SLTU   = 6'h2B;
    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REG    = 2'b11;
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd7
    } state_t;
    typedef enum logic [3:0] {
        CL_ILLEGAL = 4'd0,
        CL_R_ALU   = 4'd1,
        CL_JR      = 4'd2,
        CL_I_ALU   = 4'd3,
        CL_LOAD    = 4'd4,
        CL_STORE   = 4'd5,
        CL_BRANCH  = 4'd6,
        CL_J       = 4'd7,
        CL_JAL     = 4'd8
    } class_t;
endpackage

// File: rtl/multicycle_sequencer_instr_classifier.sv
// instr_classifier: combinational Opcode/Funct to instruction class decode
// Ports:
//   opcode      in  6  Instruction[31:26]
//   funct       in  6  Instruction[5:0], only meaningful for opcode 0
//   instr_class out 4  class_t code; CL_ILLEGAL for anything not in the supported subset
module instr_classifier
    import mips_defs::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] instr_class
);
    always_comb begin
        case (opcode)
            OP_RTYPE:
                instr_class = (funct == FN_JR) ? CL_JR :
                              (funct inside {FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                                             FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                                             FN_XOR, FN_NOR, FN_SLT, FN_SLTU}) ? CL_R_ALU : CL_ILLEGAL;
            // bgez/bltz share REGIMM; the rt field picks the condition, which the ALU evaluates
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                instr_class = CL_BRANCH;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                instr_class = CL_I_ALU;
            OP_LB, OP_LH, OP_LW:
                instr_class = CL_LOAD;
            OP_SB, OP_SH, OP_SW:
                instr_class = CL_STORE;
            OP_J:
                instr_class = CL_J;
            OP_JAL:
                instr_class = CL_JAL;
            default:
                instr_class = CL_ILLEGAL;
        endcase
    end
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM for a multicycle MIPS datapath
// Ports:
//   Clk, Reset (async, active-high)
//   Opcode, Funct   in   instruction fields from IR
//   BranchCond      in   ALU branch outcome (EXEC)
//   MemReady        in   memory finishes the current access this cycle
//   PCWrite, PCSrcSel, IRWrite, MemRead, MemWrite, RegWrite, LinkWrite  out  per-cycle enables
//   State           out  current state code
//   Fault           out  sticky illegal-instruction / memory-timeout flag
module multicycle_sequencer
    import mips_defs::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       BranchCond,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic [1:0] PCSrcSel,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       LinkWrite,
    output logic [2:0] State,
    output logic       Fault
);
    state_t             state, state_nxt;
    class_t             class_q, class_dec;
    logic [3:0]         class_raw;
    logic [CNT_W-1:0]   wait_cnt;
    logic               timeout;

    instr_classifier u_classifier (
        .opcode      (Opcode),
        .funct       (Funct),
        .instr_class (class_raw)
    );

    assign class_dec = class_t'(class_raw);
    // this waiting cycle would bring the count to MEM_WAIT_MAX; MemReady overrides it
    assign timeout   = !MemReady && (wait_cnt == CNT_W'(MEM_WAIT_MAX - 1));
    assign State     = state;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            state <= ST_FETCH;
        else
            state <= state_nxt;
    end

    // class is captured in DECODE so later IR/Opcode changes cannot disturb EXEC..WB
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            class_q  <= CL_ILLEGAL;
            wait_cnt <= '0;
        end else begin
            if (state == ST_DECODE)
                class_q <= class_dec;
            wait_cnt <= (state_nxt != state || MemReady) ? '0 :
                        (state inside {ST_FETCH, ST_MEM}) ? wait_cnt + 1'b1 : wait_cnt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH:  state_nxt = MemReady ? ST_DECODE : timeout ? ST_FAULT : ST_FETCH;
            ST_DECODE: state_nxt = (class_dec == CL_ILLEGAL) ? ST_FAULT :
                                   (class_dec == CL_J) ? ST_FETCH : ST_EXEC;
            ST_EXEC:   state_nxt = (class_q inside {CL_LOAD, CL_STORE}) ? ST_MEM :
                                   (class_q inside {CL_R_ALU, CL_I_ALU, CL_JAL}) ? ST_WB : ST_FETCH;
            ST_MEM:    state_nxt = MemReady ? ((class_q == CL_LOAD) ? ST_WB : ST_FETCH) :
                                   timeout ? ST_FAULT : ST_MEM;
            ST_WB:     state_nxt = ST_FETCH;
            default:   state_nxt = ST_FAULT;
        endcase
    end

    // Reset gates every enable so an access in flight is dropped immediately
    always_comb begin
        PCWrite   = 1'b0;
        PCSrcSel  = PC_SEQ;
        IRWrite   = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        LinkWrite = 1'b0;
        Fault     = 1'b0;
        if (!Reset) begin
            case (state)
                ST_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                ST_DECODE: begin
                    PCWrite  = (class_dec == CL_J);
                    PCSrcSel = (class_dec == CL_J) ? PC_JUMP : PC_SEQ;
                end
                ST_EXEC: begin
                    PCWrite  = (class_q == CL_BRANCH) ? BranchCond : (class_q inside {CL_JR, CL_JAL});
                    PCSrcSel = (class_q == CL_BRANCH) ? PC_BRANCH :
                               (class_q == CL_JR) ? PC_REG :
                               (class_q == CL_JAL) ? PC_JUMP : PC_SEQ;
                end
                ST_MEM: begin
                    MemRead  = (class_q == CL_LOAD);
                    MemWrite = (class_q == CL_STORE);
                end
                ST_WB: begin
                    RegWrite  = 1'b1;
                    LinkWrite = (class_q == CL_JAL);
                end
                ST_FAULT:
                    Fault = 1'b1;
                default: ;
            endcase
        end
    end
endmodule
